bpsk_dac_mod: RTL and testbench

BPSK_DAC_MOD -- requirements
Module: bpsk_dac_mod

---
 rtl/bpsk_pkg.sv | 37 +++
 rtl/sine_lut.sv | 22 ++
 rtl/bpsk_dac_mod.sv | 113 +++++++++++
 tb/tb_bpsk_dac_mod.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared widths, DAC constants, FSM encoding and the sine table generator
// used by the BPSK DAC modulator.
package bpsk_pkg;

    localparam int             DAC_W   = 14;
    localparam logic [14-1:0]  DAC_MID = 14'h2000;
    localparam int             PHASE_W = 32;
    localparam int             LUT_AW  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // round(8191*sin(2*pi*k/1024)) in Q30 integer arithmetic, evaluated at elaboration only
    function automatic logic [DAC_W-1:0] sine_code(input int k);
        longint x;
        longint term;
        longint sum;
        longint v;
        int     m;
        m = k % 256;
        if (((k / 256) % 2) == 1) m = 256 - m;
        x    = (64'sd3373259426 * longint'(m)) / 64'sd512;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = (((term * x) >>> 30) * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        v = (sum * 64'sd8191 + 64'sd536870912) >>> 30;
        if (k >= 512) v = -v;
        return v[DAC_W-1:0];
    endfunction

endpackage

// File: rtl/sine_lut.sv
// 1024 x 14 sine ROM, two's complement, registered output advanced on ce.
module sine_lut
    import bpsk_pkg::*;
(
    input  logic              clk,
    input  logic              ce,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-1:0]  q
);

    logic [DAC_W-1:0] rom [2**LUT_AW];

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        localparam logic [DAC_W-1:0] VAL = sine_code(k);
        assign rom[k] = VAL;
    end

    always_ff @(posedge clk) begin
        if (ce) q <= rom[addr];
    end

endmodule

// File: rtl/bpsk_dac_mod.sv
// BPSK modulator driving a 14-bit offset-binary DAC at clk/2; NCO phase runs
// continuously across symbols, bit 1 adds half a table turn.
//   state | meaning
//   IDLE  | accumulator cleared, DAC at midscale, waiting for a bit
//   RUN   | emitting SYM_LEN samples of the current symbol
module bpsk_dac_mod
    import bpsk_pkg::*;
#(
    parameter int          SYM_LEN = 50,
    parameter logic [31:0] FTW     = 32'h0CCC_CCCD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             trig,
    output logic             underrun,
    output logic             dac_clk,
    output logic             dac_wrt,
    output logic [DAC_W-1:0] dac_data
);

    localparam logic [9:0] LAST_CNT = 10'(SYM_LEN - 1);

    state_t              state;
    state_t              state_nxt;
    logic                ce;
    logic                armed;
    logic                cur_bit;
    logic                run_d1;
    logic                trig_d1;
    logic                last;
    logic                handshake;
    logic [9:0]          sym_cnt;
    logic [PHASE_W-1:0]  acc;
    logic [LUT_AW-1:0]   lut_addr;
    logic [DAC_W-1:0]    lut_q;

    assign last     = (sym_cnt == LAST_CNT);
    assign lut_addr = acc[PHASE_W-1 -: LUT_AW] + (cur_bit ? 10'd512 : 10'd0);
    assign dac_wrt  = dac_clk;

    always_comb begin
        bit_ready = 1'b0;
        handshake = 1'b0;
        state_nxt = state;
        if (ce && armed) begin
            case (state)
                IDLE:    bit_ready = enable;
                RUN:     bit_ready = enable && last;
                default: bit_ready = 1'b0;
            endcase
        end
        handshake = bit_ready && bit_valid;
        case (state)
            IDLE:    if (handshake) state_nxt = RUN;
            RUN:     if (ce && last && !handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // dac_clk lags ~ce by one clk so dac_data updates as dac_clk falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce       <= 1'b0;
            armed    <= 1'b0;
            dac_clk  <= 1'b1;
            cur_bit  <= 1'b0;
            sym_cnt  <= '0;
            acc      <= '0;
            underrun <= 1'b0;
            run_d1   <= 1'b0;
            trig_d1  <= 1'b0;
            trig     <= 1'b0;
            dac_data <= DAC_MID;
        end else begin
            ce      <= ~ce;
            dac_clk <= ~ce;
            if (ce) begin
                armed <= 1'b1;
                if (handshake) cur_bit <= bit_in;
                if (handshake && state == IDLE)
                    underrun <= 1'b0;
                else if (state == RUN && last && enable && !handshake)
                    underrun <= 1'b1;
                if (state == RUN && state_nxt == RUN && !last)
                    sym_cnt <= sym_cnt + 10'd1;
                else
                    sym_cnt <= '0;
                acc      <= (state == RUN && state_nxt == RUN) ? acc + FTW : '0;
                run_d1   <= (state == RUN);
                trig_d1  <= (state == RUN) && (sym_cnt == 10'd0);
                trig     <= trig_d1;
                dac_data <= run_d1 ? (lut_q ^ DAC_MID) : DAC_MID;
            end
        end
    end

    sine_lut u_lut (
        .clk  (clk),
        .ce   (ce),
        .addr (lut_addr),
        .q    (lut_q)
    );

endmodule

// File: tb/tb_bpsk_dac_mod.sv
// Directed bench for bpsk_dac_mod: idle after reset, bit sequences, random stream,
// underrun, enable drop and asynchronous reset mid-symbol.
module tb_bpsk_dac_mod;

    localparam logic [31:0] FTW_T = 32'h0CCC_CCCD;
    localparam logic [13:0] MID   = 14'h2000;
    localparam real         PI    = 3.14159265358979323846;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        trig;
    logic        underrun;
    logic        dac_clk;
    logic        dac_wrt;
    logic [13:0] dac_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit bits [64];

    bpsk_dac_mod #(.SYM_LEN(50), .FTW(FTW_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .trig      (trig),
        .underrun  (underrun),
        .dac_clk   (dac_clk),
        .dac_wrt   (dac_wrt),
        .dac_data  (dac_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) cyc++;
        @(negedge clk);
    endtask

    function automatic logic [13:0] exp_code(input int n, input bit b);
        logic [31:0] ph;
        logic [9:0]  a;
        real         v;
        int          iv;
        logic [13:0] c;
        ph = FTW_T * 32'(n);
        a  = ph[31:22] + (b ? 10'd512 : 10'd0);
        v  = 8191.0 * $sin(2.0 * PI * real'(a) / 1024.0);
        iv = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        c  = iv[13:0];
        return c ^ MID;
    endfunction

    // Runs nsym symbols from bits[]; ends by dropping enable (stop) or bit_valid (underrun).
    task automatic run_seq(input int nsym, input bit urun_mode, input int last_rel);
        int          n;
        logic [13:0] e_d;
        bit          e_tr;
        bit          e_br;
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = bits[0];
        #1;
        if (cyc % 2 == 0) begin
            chk("bit_ready_ce_low", bit_ready, 0);
            step();
            #1;
        end
        chk("bit_ready_idle", bit_ready, 1);
        step();
        for (int rel = 0; rel <= last_rel; rel++) begin
            if (rel > 0) step();
            if (rel % 100 == 0 && rel / 100 + 1 < nsym) bit_in = bits[rel / 100 + 1];
            if (urun_mode && rel == 100 * (nsym - 1)) bit_valid = 1'b0;
            if (!urun_mode && rel == 100 * (nsym - 1) + 20) enable = 1'b0;
            #1;
            n    = (rel >= 4) ? (rel - 4) / 2 : 0;
            e_d  = MID;
            e_tr = 1'b0;
            if (rel >= 4 && n < nsym * 50) begin
                e_d  = exp_code(n, bits[n / 50]);
                e_tr = (n % 50 == 0);
            end
            e_br = (rel % 2 == 1) && enable &&
                   ((((rel + 1) % 100 == 0) && (rel + 1 <= nsym * 100)) || rel > nsym * 100);
            chk("dac_data", dac_data, e_d);
            chk("trig", trig, e_tr);
            chk("bit_ready", bit_ready, e_br);
            chk("underrun", underrun, urun_mode && rel >= nsym * 100);
            chk("dac_clk", dac_clk, cyc % 2 == 1);
            chk("dac_wrt", dac_wrt, cyc % 2 == 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        step();
        step();
        #1;
        chk("rst_dac_clk", dac_clk, 1);
        chk("rst_dac_wrt", dac_wrt, 1);
        chk("rst_dac_data", dac_data, MID);
        chk("rst_trig", trig, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_underrun", underrun, 0);

        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            #1;
            chk("idle_dac_data", dac_data, MID);
            chk("idle_bit_ready", bit_ready, 0);
            chk("idle_trig", trig, 0);
            chk("idle_dac_clk", dac_clk, cyc % 2 == 1);
        end

        bits[0] = 1'b0;
        bits[1] = 1'b1;
        bits[2] = 1'b0;
        run_seq(3, 1'b0, 306);

        for (int i = 0; i < 30; i++) bits[i] = 1'($urandom_range(0, 1));
        run_seq(30, 1'b0, 3006);

        bits[0] = 1'b1;
        bits[1] = 1'b1;
        bits[2] = 1'b0;
        run_seq(3, 1'b1, 306);

        bits[0] = 1'b1;
        bits[1] = 1'b0;
        run_seq(2, 1'b0, 54);
        #3;
        rst = 1'b1;
        #1;
        chk("async_dac_clk", dac_clk, 1);
        chk("async_dac_wrt", dac_wrt, 1);
        chk("async_dac_data", dac_data, MID);
        chk("async_trig", trig, 0);
        chk("async_bit_ready", bit_ready, 0);
        chk("async_underrun", underrun, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            chk("hold_trig", trig, 0);
            chk("hold_dac_data", dac_data, MID);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
